negedge_capture_scheduler: RTL and testbench
============================================

Name: negedge_capture_scheduler

Overview:
- Round-robin scheduler that shares a single negedge-captured 7-bit register among NREQ requesters.
- Sequences grant, negedge capture, hold window and release for each requester in turn.
- Sits in front of the negedge/async-reset capture datapath.
- Control FSM runs on posedge clkin_data; the capture register loads on negedge clkin_data.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 7, captured field width
LEN_W, 4, width of per-requester hold length

Ports:
clkin_data  input  1  clock; FSM on posedge, capture register on negedge
reset  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester capture request, level
req_data  input  NREQ*DW  field for requester i at [i*DW +: DW]
req_len  input  NREQ*LEN_W  hold length for requester i at [i*LEN_W +: LEN_W]
grant  output  NREQ  one-hot grant to current owner
busy  output  1  FSM not in IDLE
cap_valid  output  1  cap_data holds the owner's captured field
cap_data  output  DW  negedge-captured field
cap_owner  output  $clog2(NREQ)  index of current/last owner
done  output  1  one-cycle pulse at end of a transaction

Behaviour:
- Reset (async, wins over any edge):
  - state=IDLE; grant=0, busy=0, cap_valid=0, done=0, cap_data=0, cap_owner=0, rr pointer=0.
  - cap_data clears immediately on reset assertion, not at the next negedge.
- States: IDLE, CAPTURE, HOLD, RELEASE.
- IDLE:
  - At a posedge with req!=0, pick the first set req[i] scanning from the pointer upward, wrapping modulo NREQ.
  - On that edge: latch owner into cap_owner, set grant[owner], latch req_len[owner] into hold counter, go to CAPTURE.
- CAPTURE (exactly 1 cycle):
  - At the negedge inside this cycle, cap_data <= req_data[owner].
  - Next posedge: cap_valid=1, go to HOLD.
- HOLD:
  - Counter decrements each posedge; on the posedge where counter==0, go to RELEASE.
  - req_len=0 gives 1 HOLD cycle; req_len=L gives L+1 HOLD cycles.
  - Grant stays high L+2 cycles in total.
- Early abort: if req[owner] is low at a posedge in CAPTURE or HOLD, go straight to RELEASE.
  - cap_valid is not asserted if the abort happens in CAPTURE.
- RELEASE (1 cycle):
  - grant=0, cap_valid=0, done=1, pointer=(owner+1) mod NREQ.
  - Next posedge returns to IDLE. A new grant is issued no earlier than the posedge after RELEASE.
- cap_data:
  - Holds its value after release until the next CAPTURE negedge or reset; only the CAPTURE-cycle negedge loads it.
  - Requests and data changing outside CAPTURE have no effect on cap_data.
- Priority order: the pointer gives fairness. After owner k, requester k+1 has highest priority.
- Reset mid-operation: everything returns to reset values at once. The interrupted owner gets no done pulse, and the pointer returns to 0.
- busy=1 in CAPTURE, HOLD and RELEASE.

Optional Feature:
- CAPTURE_OR_REDUCE_EN defined:
  - cap_data[0] captures the OR-reduction of the upper DW-1 bits of req_data[owner]; cap_data[DW-1:1] captures req_data[owner][DW-1:1].
  - Same negedge, same reset.
- Not defined: cap_data captures req_data[owner] unchanged.

Test Plan:
- Reset low, req=4'b0001, req_data[0]=7'h1F, req_len[0]=2:
  - grant=0001 for 4 cycles; cap_data=7'h1F at the first negedge after grant.
  - cap_valid high 3 cycles, then done pulse; cap_owner=0.
- req=4'b1111, all req_len=0: grants in order 0,1,2,3,0; each grant lasts 2 cycles, separated by a RELEASE cycle.
- Assert reset during HOLD with cap_data=7'h2A: cap_data=0, grant=0 and cap_valid=0 immediately, before any clock edge; no done pulse; next grant goes to req[0] first.
- Drop req[owner] mid-HOLD with req_len=15: RELEASE at the next posedge, done=1, pointer advances; cap_data keeps its captured value.
- Change req_data[owner] from 7'h11 to 7'h22 during HOLD: cap_data stays 7'h11.
- With CAPTURE_OR_REDUCE_EN, req_data[owner]=7'b1000000: cap_data=7'b1000001. Without it: cap_data=7'b1000000.

Source files
------------

// File: rtl/negedge_capture_scheduler_if.sv
// Request/grant/capture bundle shared between the requesters and the negedge
// capture scheduler. The master side drives requests; the slave side is the scheduler.
interface negedge_capture_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int DW    = 7,
    parameter int LEN_W = 4
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*DW-1:0]    req_data;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  cap_valid;
    logic [DW-1:0]         cap_data;
    logic [OW-1:0]         cap_owner;
    logic                  done;

    modport master (
        output req, req_data, req_len,
        input  grant, busy, cap_valid, cap_data, cap_owner, done
    );

    modport slave (
        input  req, req_data, req_len,
        output grant, busy, cap_valid, cap_data, cap_owner, done
    );
endinterface

// File: rtl/negedge_capture_scheduler.sv
// Round-robin owner of a single negedge-loaded capture register: grant, capture, hold, release.
// Optional build macro CAPTURE_OR_REDUCE_EN folds the OR of the upper field bits into bit 0.
module negedge_capture_scheduler #(
    parameter int NREQ  = 4,
    parameter int DW    = 7,
    parameter int LEN_W = 4
) (
    input logic                   clkin_data,
    input logic                   reset,
    negedge_capture_scheduler_if.slave bus
);
    localparam int OW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [OW-1:0]    owner, owner_nxt;
    logic [OW-1:0]    ptr, ptr_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [DW-1:0]    cap_field_p0;
    logic             found;
    logic [OW-1:0]    pick;
    int               idx;

    function automatic logic [DW-1:0] capture_field(input logic [DW-1:0] d);
`ifdef CAPTURE_OR_REDUCE_EN
        return {d[DW-1:1], |d[DW-1:1]};
`else
        return d;
`endif
    endfunction

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
        if (int'(v) == NREQ - 1) begin
            return '0;
        end
        return v + OW'(1);
    endfunction

    // First pending request at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && bus.req[OW'(idx)]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    always_ff @(posedge clkin_data or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt = pick;
                    cnt_nxt   = bus.req_len[int'(pick)*LEN_W +: LEN_W];
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!bus.req[owner]) begin
                    state_nxt = RELEASE;
                    ptr_nxt   = wrap_inc(owner);
                end else begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // A dropped request ends the hold early, same as an expired count.
                if (!bus.req[owner] || cnt == '0) begin
                    state_nxt = RELEASE;
                    ptr_nxt   = wrap_inc(owner);
                end else begin
                    cnt_nxt = cnt - LEN_W'(1);
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.grant = '0;
        if (state == CAPTURE || state == HOLD) begin
            bus.grant[owner] = 1'b1;
        end
        bus.busy      = (state != IDLE);
        bus.cap_valid = (state == HOLD);
        bus.done      = (state == RELEASE);
        bus.cap_owner = owner;
        bus.cap_data  = cap_field_p0;
    end

    // Capture stage: loads on the falling edge inside the CAPTURE cycle only.
    always_ff @(negedge clkin_data or posedge reset) begin
        if (reset) begin
            cap_field_p0 <= '0;
        end else if (state == CAPTURE) begin
            cap_field_p0 <= capture_field(bus.req_data[int'(owner)*DW +: DW]);
        end
    end
endmodule

// File: tb/tb_negedge_capture_scheduler.sv
// Scoreboard bench for negedge_capture_scheduler: expected transactions are queued
// as requests are driven and retired on each done pulse.
module tb_negedge_capture_scheduler;
    localparam int NREQ  = 4;
    localparam int DW    = 7;
    localparam int LEN_W = 4;

`ifdef CAPTURE_OR_REDUCE_EN
    localparam logic [DW-1:0] T6_EXP = 7'b1000001;
`else
    localparam logic [DW-1:0] T6_EXP = 7'b1000000;
`endif

    logic clkin_data = 1'b0;
    logic reset      = 1'b1;

    negedge_capture_scheduler_if #(.NREQ(NREQ), .DW(DW), .LEN_W(LEN_W)) bus ();

    negedge_capture_scheduler #(.NREQ(NREQ), .DW(DW), .LEN_W(LEN_W)) dut (
        .clkin_data (clkin_data),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 clkin_data = ~clkin_data;

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        int            gcy;
        int            vcy;
    } txn_t;

    txn_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_field(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
`ifdef CAPTURE_OR_REDUCE_EN
        r[0] = ((d >> 1) != '0);
`endif
        return r;
    endfunction

    task automatic expect_txn(input int owner, input logic [DW-1:0] raw, input int gcy, input int vcy);
        txn_t t;
        t.owner = owner;
        t.data  = exp_field(raw);
        t.gcy   = gcy;
        t.vcy   = vcy;
        sb.push_back(t);
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] d, input logic [LEN_W-1:0] len);
        bus.req_data[i*DW +: DW]       = d;
        bus.req_len[i*LEN_W +: LEN_W]  = len;
    endtask

    task automatic tick_sample();
        @(negedge clkin_data);
        #2;
    endtask

    task automatic wait_dones(input string tag, input int n, input int budget);
        int seen;
        seen = 0;
        for (int c = 0; c < budget && seen < n; c++) begin
            tick_sample();
            if (bus.done) seen++;
        end
        chk(tag, seen, n);
    endtask

    // which: 0 = any grant, 1 = cap_valid
    task automatic wait_sig(input string tag, input int which, input int budget);
        int ok;
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            tick_sample();
            if ((which == 0 && bus.grant != '0) || (which == 1 && bus.cap_valid)) begin
                ok = 1;
                break;
            end
        end
        chk(tag, ok, 1);
    endtask

    task automatic drop_after_edge();
        @(posedge clkin_data);
        #1;
        bus.req = '0;
    endtask

    // Scoreboard side: count grant/valid/busy cycles per transaction, retire on done.
    initial begin
        int              g, v, b;
        logic [NREQ-1:0] gval;
        txn_t            e;
        g = 0; v = 0; b = 0; gval = '0;
        forever begin
            tick_sample();
            if (reset) begin
                g = 0; v = 0; b = 0;
            end else begin
                if (bus.grant != '0) begin
                    g++;
                    gval = bus.grant;
                end
                if (bus.cap_valid) v++;
                if (bus.busy) b++;
                if (bus.done) begin
                    chk("sb_pending", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("owner",        bus.cap_owner, e.owner);
                        chk("grant_onehot", gval,          1 << e.owner);
                        chk("cap_data",     bus.cap_data,  e.data);
                        chk("grant_cycles", g,             e.gcy);
                        chk("valid_cycles", v,             e.vcy);
                        chk("busy_cycles",  b,             e.gcy + 1);
                    end
                    g = 0; v = 0; b = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d2 [4];
        d2[0] = 7'h03; d2[1] = 7'h35; d2[2] = 7'h5A; d2[3] = 7'h7C;

        bus.req      = '0;
        bus.req_data = '0;
        bus.req_len  = '0;

        // Reset state
        repeat (2) tick_sample();
        chk("rst_grant",     bus.grant,     0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_cap_valid", bus.cap_valid, 0);
        chk("rst_done",      bus.done,      0);
        chk("rst_cap_data",  bus.cap_data,  0);
        chk("rst_cap_owner", bus.cap_owner, 0);
        @(posedge clkin_data); #1; reset = 1'b0;

        // Single requester, hold length 2
        set_lane(0, 7'h1F, 2);
        expect_txn(0, 7'h1F, 4, 3);
        bus.req = 4'b0001;
        wait_sig("t1_grant_seen", 0, 10);
        chk("t1_grant_val", bus.grant, 4'b0001);
        chk("t1_cap_first_negedge", bus.cap_data, exp_field(7'h1F));
        wait_dones("t1_done", 1, 20);
        drop_after_edge();
        repeat (3) tick_sample();

        // Round robin over all four with zero hold length, from a fresh pointer
        reset = 1'b1;
        tick_sample();
        @(posedge clkin_data); #1; reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_lane(i, d2[i], 0);
        for (int i = 0; i < 5; i++) expect_txn(i % NREQ, d2[i % NREQ], 2, 1);
        bus.req = 4'b1111;
        wait_dones("t2_done", 5, 60);
        drop_after_edge();
        repeat (3) tick_sample();

        // Asynchronous reset during HOLD
        set_lane(0, 7'h2A, 5);
        bus.req = 4'b0001;
        wait_sig("t3_valid_seen", 1, 10);
        chk("t3_cap_before_reset", bus.cap_data, exp_field(7'h2A));
        #1; reset = 1'b1;
        #1;
        chk("t3_async_cap_data",  bus.cap_data,  0);
        chk("t3_async_grant",     bus.grant,     0);
        chk("t3_async_cap_valid", bus.cap_valid, 0);
        chk("t3_async_busy",      bus.busy,      0);
        chk("t3_async_done",      bus.done,      0);
        set_lane(0, 7'h0C, 0);
        set_lane(1, 7'h66, 0);
        bus.req = 4'b0011;
        expect_txn(0, 7'h0C, 2, 1);
        expect_txn(1, 7'h66, 2, 1);
        repeat (2) @(posedge clkin_data);
        #1; reset = 1'b0;
        wait_dones("t3_done", 2, 30);
        drop_after_edge();
        repeat (3) tick_sample();

        // Early abort in HOLD with the longest hold length
        set_lane(2, 7'h55, 15);
        expect_txn(2, 7'h55, 4, 3);
        bus.req = 4'b0100;
        wait_sig("t4_valid_seen", 1, 10);
        @(posedge clkin_data);
        @(posedge clkin_data);
        #1; bus.req = '0;
        wait_dones("t4_done", 1, 10);
        repeat (2) tick_sample();
        chk("t4_cap_hold", bus.cap_data, exp_field(7'h55));
        // Pointer moved past 2, so 3 wins with everyone requesting
        for (int i = 0; i < NREQ; i++) set_lane(i, d2[i], 0);
        set_lane(3, 7'h19, 0);
        expect_txn(3, 7'h19, 2, 1);
        bus.req = 4'b1111;
        wait_dones("t4_ptr_done", 1, 20);
        drop_after_edge();
        repeat (3) tick_sample();

        // Data changing during HOLD leaves the captured value alone
        set_lane(0, 7'h11, 3);
        expect_txn(0, 7'h11, 5, 4);
        bus.req = 4'b0001;
        wait_sig("t5_valid_seen", 1, 10);
        set_lane(0, 7'h22, 3);
        tick_sample();
        chk("t5_cap_stable", bus.cap_data, exp_field(7'h11));
        wait_dones("t5_done", 1, 20);
        drop_after_edge();
        repeat (3) tick_sample();

        // Field folding
        set_lane(1, 7'b1000000, 0);
        expect_txn(1, 7'b1000000, 2, 1);
        bus.req = 4'b0010;
        wait_sig("t6_grant_seen", 0, 10);
        chk("t6_fold", bus.cap_data, T6_EXP);
        wait_dones("t6_done", 1, 10);
        drop_after_edge();
        repeat (3) tick_sample();
        set_lane(1, 7'h01, 0);
        expect_txn(1, 7'h01, 2, 1);
        bus.req = 4'b0010;
        wait_dones("t6b_done", 1, 20);
        drop_after_edge();
        repeat (3) tick_sample();

        // Abort inside CAPTURE: captured, but never valid
        set_lane(3, 7'h3C, 4);
        expect_txn(3, 7'h3C, 1, 0);
        bus.req = 4'b1000;
        wait_sig("t7_grant_seen", 0, 10);
        bus.req = '0;
        wait_dones("t7_done", 1, 10);
        repeat (3) tick_sample();

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
